// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared types and helpers for the data-memory channel arbiter.
//   - channel_state_t : per-channel FSM state encoding.
//   - idx_wrap()      : wraps an index that may have stepped one modulus past
//                       the end back into range. It works for any modulus, so
//                       consumer counts need not be powers of two.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        READ_RELAY,
        WRITE_RELAY
    } channel_state_t;

    // Callers only ever hand in values below 2*modulus, so a single
    // subtraction replaces a general modulo.
    function automatic int idx_wrap(input int value, input int modulus);
        return (value >= modulus) ? (value - modulus) : value;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin finder. It scans the request mask starting at
//   start_i and wraps modulo N. It returns the first index that is requesting
//   and is not excluded.
//
//   Ports:
//     req_i    [N-1:0]  requesting consumers
//     excl_i   [N-1:0]  consumers that may not be picked (busy or claimed)
//     start_i  [W-1:0]  first index to examine (always < N)
//     found_o           a candidate was found
//     idx_o    [W-1:0]  index of the candidate (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] excl_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    int cand;

    // NOTE: every output gets a default before the loop, so no path through
    // the block leaves a value unassigned. Without the defaults, a latch would
    // be inferred.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = idx_wrap(int'(start_i) + k, N);
            if (!found_o && req_i[cand] && !excl_i[cand]) begin
                found_o = 1'b1;
                idx_o   = W'(cand);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS dcache
//   memory-side ports. The arbiter serves both reads and writes. Each channel
//   runs its own FSM:
//     IDLE -> READ_WAIT/WRITE_WAIT -> READ_RELAY/WRITE_RELAY -> IDLE.
//   In IDLE, a channel picks a consumer round-robin. Claims resolve in
//   ascending channel order, so one consumer is never granted to two channels
//   at once.
//
//   Ports (packed vectors; consumer i / channel c at [i*W +: W] / [c*W +: W]):
//     clk, reset                    rising-edge clock, async active-low reset
//     consumer_read_valid/_address  level read request from each consumer
//     consumer_read_ready/_data     read done; data held until the next read
//     consumer_write_valid/_address/_data   level write request
//     consumer_write_ready          write acknowledged
//     mem_read_valid/_address       per-channel read request to memory
//     mem_read_ready/_data          memory read done, data valid that cycle
//     mem_write_valid/_address/_data        per-channel write request
//     mem_write_ready               memory write done
//     channel_busy                  channel FSM not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,

    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,

    output logic [NUM_CHANNELS-1:0]            channel_busy
);

    // Consumer index width. It stays at least 1 bit, so a single consumer
    // still gets a real index register.
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    // ---------------------------------------------------------------------
    // Unpacked views of the packed buses
    // ---------------------------------------------------------------------
    logic [ADDR_BITS-1:0] rd_addr   [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] wr_addr   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] wr_data   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] mem_rdata [NUM_CHANNELS];

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    // Per consumer
    logic [NUM_CONSUMERS-1:0] busy_q;
    logic [NUM_CONSUMERS-1:0] rd_ready_q;
    logic [NUM_CONSUMERS-1:0] wr_ready_q;
    logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];

    // Per channel
    channel_state_t           state_q       [NUM_CHANNELS];
    logic [CW-1:0]            owner_q       [NUM_CHANNELS];
    logic [CW-1:0]            rr_ptr_q      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_rd_valid_q;
    logic [NUM_CHANNELS-1:0]  mem_wr_valid_q;
    logic [ADDR_BITS-1:0]     mem_rd_addr_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_wr_addr_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_wr_data_q [NUM_CHANNELS];

    // Grant decisions for this cycle, one per channel
    logic [NUM_CONSUMERS-1:0] cons_req;
    logic [NUM_CHANNELS-1:0]  pick_found;
    logic [CW-1:0]            pick_idx [NUM_CHANNELS];

    assign cons_req = consumer_read_valid | consumer_write_valid;

    // ---------------------------------------------------------------------
    // Consumer-side bus packing
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_cons
        assign rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;

    // ---------------------------------------------------------------------
    // Per-channel pickers, chained through the exclusion mask. Channel c sees
    // every consumer that is already busy or was claimed by channels 0..c-1.
    // A channel that is not IDLE claims nothing and passes the mask through.
    // ---------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] excl_in;
        logic [NUM_CONSUMERS-1:0] excl_out;
        logic                     found;
        logic [CW-1:0]            idx;
        logic                     idle;

        if (c == 0) begin : g_head
            assign excl_in = busy_q;
        end else begin : g_link
            assign excl_in = g_ch[c-1].excl_out;
        end

        rr_pick #(
            .N (NUM_CONSUMERS),
            .W (CW)
        ) u_pick (
            .req_i   (cons_req),
            .excl_i  (excl_in),
            .start_i (rr_ptr_q[c]),
            .found_o (found),
            .idx_o   (idx)
        );

        assign idle          = (state_q[c] == IDLE);
        assign excl_out      = excl_in |
                               ((idle && found) ? (NUM_CONSUMERS'(1) << idx) : '0);
        assign pick_found[c] = idle && found;
        assign pick_idx[c]   = idx;

        // Memory-side bus packing
        assign mem_rdata[c]                                = mem_read_data[c*DATA_BITS +: DATA_BITS];
        assign mem_read_valid[c]                           = mem_rd_valid_q[c];
        assign mem_read_address[c*ADDR_BITS +: ADDR_BITS]  = mem_rd_addr_q[c];
        assign mem_write_valid[c]                          = mem_wr_valid_q[c];
        assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = mem_wr_addr_q[c];
        assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = mem_wr_data_q[c];
        assign channel_busy[c]                             = !idle;
    end

    // ---------------------------------------------------------------------
    // Channel FSMs and consumer-side registers.
    // Each consumer is owned by at most one channel at a time, so the
    // per-consumer bits written inside the loop never collide.
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from pre-edge values, whatever the loop order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q         <= '0;
            rd_ready_q     <= '0;
            wr_ready_q     <= '0;
            mem_rd_valid_q <= '0;
            mem_wr_valid_q <= '0;
            // NOTE: the captured read data is reset too, not just the
            // control. Consumers can observe it, and it must read 0 after
            // reset.
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rd_data_q[i] <= '0;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]       <= IDLE;
                owner_q[c]       <= '0;
                rr_ptr_q[c]      <= '0;
                mem_rd_addr_q[c] <= '0;
                mem_wr_addr_q[c] <= '0;
                mem_wr_data_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                unique case (state_q[c])
                    IDLE: begin
                        if (pick_found[c]) begin
                            owner_q[c]            <= pick_idx[c];
                            busy_q[pick_idx[c]]   <= 1'b1;
                            rr_ptr_q[c]           <= CW'(idx_wrap(int'(pick_idx[c]) + 1,
                                                                  NUM_CONSUMERS));
                            // A consumer with both valids gets its read
                            // first. The write stays pending for a later
                            // grant.
                            if (consumer_read_valid[pick_idx[c]]) begin
                                state_q[c]        <= READ_WAIT;
                                mem_rd_valid_q[c] <= 1'b1;
                                mem_rd_addr_q[c]  <= rd_addr[pick_idx[c]];
                            end else begin
                                state_q[c]        <= WRITE_WAIT;
                                mem_wr_valid_q[c] <= 1'b1;
                                mem_wr_addr_q[c]  <= wr_addr[pick_idx[c]];
                                mem_wr_data_q[c]  <= wr_data[pick_idx[c]];
                            end
                        end
                    end

                    READ_WAIT: begin
                        if (mem_read_ready[c]) begin
                            rd_data_q[owner_q[c]]  <= mem_rdata[c];
                            rd_ready_q[owner_q[c]] <= 1'b1;
                            mem_rd_valid_q[c]      <= 1'b0;
                            state_q[c]             <= READ_RELAY;
                        end
                    end

                    WRITE_WAIT: begin
                        if (mem_write_ready[c]) begin
                            wr_ready_q[owner_q[c]] <= 1'b1;
                            mem_wr_valid_q[c]      <= 1'b0;
                            state_q[c]             <= WRITE_RELAY;
                        end
                    end

                    READ_RELAY: begin
                        if (!consumer_read_valid[owner_q[c]]) begin
                            rd_ready_q[owner_q[c]] <= 1'b0;
                            busy_q[owner_q[c]]     <= 1'b0;
                            state_q[c]             <= IDLE;
                        end
                    end

                    WRITE_RELAY: begin
                        if (!consumer_write_valid[owner_q[c]]) begin
                            wr_ready_q[owner_q[c]] <= 1'b0;
                            busy_q[owner_q[c]]     <= 1'b0;
                            state_q[c]             <= IDLE;
                        end
                    end

                    default: begin
                        state_q[c] <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS per-thread dcache memory-side ports, for both reads and writes.
- Sits between the cores' dcache mem_* ports and the external data memory.
- Each channel runs its own FSM with round-robin consumer selection.
- Each request uses a level valid/ready handshake, held until the requester drops valid.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width
NUM_CONSUMERS, 8, requesting ports (cores x threads); any value >= 1, power of two not required
NUM_CHANNELS, 4, concurrent memory channels; 1 <= NUM_CHANNELS <= NUM_CONSUMERS

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
consumer_read_valid  in  NUM_CONSUMERS  read request, level, held until ready seen
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed, consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read data valid, held until consumer drops valid
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
consumer_write_valid  in  NUM_CONSUMERS  write request, level
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  out  NUM_CONSUMERS  write acknowledged
mem_read_valid  out  NUM_CHANNELS  per-channel read request
mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed
mem_read_ready  in  NUM_CHANNELS  memory read done; data valid this cycle
mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed
mem_write_valid  out  NUM_CHANNELS  per-channel write request
mem_write_address  out  NUM_CHANNELS*ADDR_BITS  packed
mem_write_data  out  NUM_CHANNELS*DATA_BITS  packed
mem_write_ready  in  NUM_CHANNELS  memory write done
channel_busy  out  NUM_CHANNELS  channel state != IDLE

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs 0, all channel states IDLE, rr_ptr[c]=0, consumer_busy=0, captured read data 0.
  - Reset mid-transaction aborts immediately; mem valids drop; no completion is reported.
- Per-channel states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE selection:
  - Scan consumers in order rr_ptr[c], rr_ptr[c]+1, ... modulo NUM_CONSUMERS.
  - Pick the first consumer with (read_valid | write_valid), not consumer_busy, and not claimed this cycle by a lower-index channel. Claims resolve combinationally in ascending channel order, so a consumer is never granted to two channels.
  - If that consumer has both valids, read wins; its write is served in a later grant.
- On grant at edge t:
  - Next state is READ_WAIT or WRITE_WAIT.
  - Registered mem_*_valid, address and (write) data appear at t+1.
  - consumer_busy[i] is set; channel records the consumer index.
  - rr_ptr[c] = (i+1) mod NUM_CONSUMERS, with explicit wrap, not power-of-two truncation.
- READ_WAIT: on mem_read_ready, capture data into consumer i's read-data register, drop mem_read_valid, set consumer_read_ready[i], go to READ_RELAY.
- WRITE_WAIT: on mem_write_ready, drop mem_write_valid, set consumer_write_ready[i], go to WRITE_WRELAY.
  - mem ready is only sampled in WAIT states; ready in IDLE is ignored.
- RELAY: when consumer i drops the matching valid, clear ready and consumer_busy[i], go to IDLE.
  - The channel may grant again in the cycle after it returns to IDLE.
- Latency: request at cycle 0 → mem valid at 1. Ready at k → consumer ready at k+1. Consumer valid low at m → ready low at m+1.
- consumer_read_data[i] holds its value after completion until the next read completes for i.
- Outputs for consumers not currently served are 0 ready; mem outputs of IDLE channels are 0.
- A consumer dropping valid during WAIT is not supported; the transaction still completes to memory.

Decomposition:
- Shared package dmem_arbiter_pkg:
  - channel_state_t enum (IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY).
  - Function idx_wrap(value, modulus).
- One sub-module: rr_pick.
  - Combinational; takes request mask, exclusion mask and start pointer.
  - Returns found and index.
  - Instantiated per channel and chained through the exclusion mask.

Test Plan:
- Single read: consumer 2 reads addr 0x10; memory returns 0xAB after 3 cycles → channel 0 mem_read_valid at t+1 with address 0x10; consumer_read_ready[2] one cycle after mem ready with data 0xAB; consumer_busy clears after valid drops.
- Write: consumer 5 writes 0x3C to 0x20 → mem_write_valid/addr 0x20/data 0x3C on channel 0; consumer_write_ready[5] after mem_write_ready; memory model holds 0x3C.
- Contention: all 8 consumers read, NUM_CHANNELS=4, fixed 2-cycle memory → first round grants consumers 0-3 to channels 0-3, no duplicates; all 8 complete with correct data; no consumer waits more than 2 rounds.
- Round-robin wrap: NUM_CONSUMERS=5, NUM_CHANNELS=1, consumers 0 and 4 requesting continuously → grants alternate 0,4,0,4; rr_ptr wraps from 4 to 0.
- Read+write same consumer: consumer 1 asserts read addr 0x05 and write addr 0x06 together → read served first, write granted only after the read relay completes.
- Reset mid-op: reset low during READ_WAIT → all mem valids and consumer readys go 0 asynchronously; after release, a fresh request from consumer 0 is granted to channel 0.
